pixel_image_top: RTL and testbench
==================================

# pixel_image_top

Small RGB frame-buffer engine holding a W×H image of 24-bit pixels (8-bit R, G, B) in flip-flops. It executes one command at a time:
- fill the whole image with a colour;
- write one pixel;
- read one pixel, returned both as channels and packed 24-bit;
- invert every pixel;
- convert every pixel to grayscale.

It serves as the pixel-store demonstrator at the top of the design and is driven by a controller or bench through a valid/ready command port.

## Interface
Parameters:
- W, 4, image width in pixels (x = 0..W-1)
- H, 3, image height in pixels (y = 0..H-1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle and able to accept a command
- cmd_op  in  3  0=FILL, 1=SET, 2=GET, 3=INVERT, 4=GRAY, 5–7 = NOP
- cmd_x  in  $clog2(W)+1  pixel x (SET/GET)
- cmd_y  in  $clog2(H)+1  pixel y (SET/GET)
- cmd_r, cmd_g, cmd_b  in  8 each  colour (FILL/SET)
- done  out  1  one-cycle pulse when a command completes
- rsp_valid  out  1  one-cycle pulse with GET result
- rsp_ok  out  1  GET coordinate was in range
- rsp_r, rsp_g, rsp_b  out  8 each  GET pixel channels
- rsp_rgb24  out  24  packed pixel {R[23:16], G[15:8], B[7:0]}
- err  out  1  one-cycle pulse: SET or GET with out-of-range coordinate

## Operation
- Storage: W·H entries × 24 bits. Pixel index = y·W + x.
- A command is accepted on the rising edge where cmd_valid && cmd_ready. Operands are captured at acceptance.
- FILL: writes {cmd_r, cmd_g, cmd_b} to every pixel.
- SET: writes the captured colour to (x, y) if x<W and y<H. Otherwise memory is unchanged and err pulses.
- GET, in range: rsp_ok=1, rsp_r/g/b = stored channels, rsp_rgb24 = packed value.
- GET, out of range: rsp_ok=0, all rsp data 0, err pulses.
- INVERT: each channel c becomes 8'hFF − c.
- GRAY: Y = (77·R + 150·G + 29·B) >> 8, computed with a 16-bit accumulator (weights sum to 256, so Y ≤ 255). R=G=B=Y is written back.
- NOP opcodes complete immediately with done and no state change.
- States:
  - IDLE: cmd_ready=1.
  - SWEEP (FILL/INVERT/GRAY): processes index 0..W·H−1, one pixel per cycle.
  - SINGLE (SET/GET/NOP): one cycle.
  - On completion, done pulses and the engine returns to IDLE.
- rsp_* and rsp_ok hold their last values until the next GET.

## Timing
- Reset (asynchronous assert, synchronous release): all pixels 24'h000000, state IDLE, cmd_ready=1, done=0, rsp_valid=0, rsp_ok=0, rsp_* = 0, err=0.
- SET/GET/NOP: accepted at edge N. At edge N+1, the write is committed or rsp_valid/done/err are asserted. cmd_ready is low during the cycle between N and N+1.
- FILL/INVERT/GRAY: accepted at edge N. Pixel i is updated at edge N+1+i. done asserts at edge N+W·H (coincident with the last write). cmd_ready is low for W·H cycles.
- cmd_ready returns high in the cycle after done. Back-to-back commands are therefore accepted every 2 cycles (single) or every W·H+1 cycles (sweep).
- cmd_valid while cmd_ready=0 is ignored; the command is not queued.
- Reset asserted mid-sweep aborts immediately. The image is cleared to 0 and no done is produced.

## Test plan
- Reset, then GET(0,0) -> rsp_ok=1, rgb24=000000. GET(4,0) -> rsp_ok=0, err pulse, data 0.
- FILL 0000FF. SET (0,0)=FF0000, (1,0)=00FF00, (2,0)=FFFFFF, (3,2)=808000. GET(2,0) -> FFFFFF, rsp_ok=1, rgb24=FFFFFF. GET(1,1) -> 0000FF.
- INVERT. Then GET (0,0) -> 00FFFF, (1,0) -> FF00FF, (2,0) -> 000000, (3,2) -> 7F7FFF, (1,1) -> FFFF00. done exactly 12 cycles after acceptance.
- GRAY after the previous step. Then GET (0,0) -> B2B2B2, (1,0) -> 696969, (2,0) -> 000000, (3,2) -> 8D8D8D, (1,1) -> E2E2E2.
- SET (0,2) from unpacked FF00FF -> GET(0,2)=FF00FF. Other pixels are unchanged.
- Assert rst_n low mid-FILL -> all outputs at reset values, every GET returns 000000. cmd_valid asserted while busy -> command dropped.

Source files
------------

// File: rtl/pixel_image_top.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_image_top
//  Purpose  : RGB frame-buffer engine. Holds a W x H image of 24-bit pixels
//             in flip-flops and runs one command at a time: FILL, SET, GET,
//             INVERT and GRAY (luma conversion).
//  Ports    : clk, rst_n             - clock, async active-low reset
//             cmd_valid/cmd_ready    - command handshake
//             cmd_op, cmd_x, cmd_y   - opcode and pixel coordinate
//             cmd_r/g/b              - colour operand
//             done                   - one-cycle pulse at command completion
//             rsp_valid, rsp_ok      - GET result pulse and in-range flag
//             rsp_r/g/b, rsp_rgb24   - GET pixel (held until the next GET)
//             err                    - pulse on out-of-range SET/GET
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_image_top #(
  parameter int W = 4,
  parameter int H = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [$clog2(W):0]   cmd_x,
  input  logic [$clog2(H):0]   cmd_y,
  input  logic [7:0]           cmd_r,
  input  logic [7:0]           cmd_g,
  input  logic [7:0]           cmd_b,
  output logic                 done,
  output logic                 rsp_valid,
  output logic                 rsp_ok,
  output logic [7:0]           rsp_r,
  output logic [7:0]           rsp_g,
  output logic [7:0]           rsp_b,
  output logic [23:0]          rsp_rgb24,
  output logic                 err
);

  localparam int c_N  = W * H;
  localparam int c_IW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_XW = $clog2(W) + 1;
  localparam int c_YW = $clog2(H) + 1;

  localparam logic [2:0] c_OP_FILL   = 3'd0;
  localparam logic [2:0] c_OP_SET    = 3'd1;
  localparam logic [2:0] c_OP_GET    = 3'd2;
  localparam logic [2:0] c_OP_INVERT = 3'd3;
  localparam logic [2:0] c_OP_GRAY   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWEEP  = 2'd1,
    S_SINGLE = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [c_XW-1:0]   r_x;
  logic [c_YW-1:0]   r_y;
  logic [23:0]       r_rgb;
  logic [c_IW-1:0]   r_idx;
  logic [23:0]       r_mem [c_N];

  logic              w_in_range;
  logic [c_IW-1:0]   w_idx;
  logic [23:0]       w_cur;
  logic [15:0]       w_acc;
  logic [7:0]        w_luma;
  logic [23:0]       w_sweep_pix;
  logic              w_is_sweep_op;

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_r     = rsp_rgb24[23:16];
  assign rsp_g     = rsp_rgb24[15:8];
  assign rsp_b     = rsp_rgb24[7:0];

  // Coordinates are one bit wider than needed so that W and H themselves are
  // representable and out-of-range requests can be detected.
  assign w_in_range = (r_x < c_XW'(W)) && (r_y < c_YW'(H));
  assign w_idx      = c_IW'(r_y) * c_IW'(W) + c_IW'(r_x);

  assign w_is_sweep_op = (cmd_op == c_OP_FILL) || (cmd_op == c_OP_INVERT) ||
                         (cmd_op == c_OP_GRAY);

  // Luma weights sum to 256, so the 16-bit sum never overflows and its top
  // byte is the 8-bit gray level.
  assign w_cur  = r_mem[r_idx];
  assign w_acc  = 16'd77  * {8'd0, w_cur[23:16]} +
                  16'd150 * {8'd0, w_cur[15:8]}  +
                  16'd29  * {8'd0, w_cur[7:0]};
  assign w_luma = 8'(w_acc >> 8);

  always_comb begin
    w_sweep_pix = w_cur;
    case (r_op)
      c_OP_FILL:   w_sweep_pix = r_rgb;
      c_OP_INVERT: w_sweep_pix = ~w_cur;   // 8'hFF - c per channel
      c_OP_GRAY:   w_sweep_pix = {w_luma, w_luma, w_luma};
      default:     w_sweep_pix = w_cur;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= 3'd0;
      r_x       <= '0;
      r_y       <= '0;
      r_rgb     <= 24'h000000;
      r_idx     <= '0;
      done      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rsp_rgb24 <= 24'h000000;
      err       <= 1'b0;
      for (int i = 0; i < c_N; i++) begin
        r_mem[i] <= 24'h000000;
      end
    end else begin
      done      <= 1'b0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op  <= cmd_op;
            r_x   <= cmd_x;
            r_y   <= cmd_y;
            r_rgb <= {cmd_r, cmd_g, cmd_b};
            r_idx <= '0;
            r_state <= w_is_sweep_op ? S_SWEEP : S_SINGLE;
          end
        end

        // One pixel per cycle; done coincides with the last write.
        S_SWEEP: begin
          r_mem[r_idx] <= w_sweep_pix;
          if (r_idx == c_IW'(c_N - 1)) begin
            done    <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + c_IW'(1);
          end
        end

        S_SINGLE: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
          case (r_op)
            c_OP_SET: begin
              if (w_in_range) begin
                r_mem[w_idx] <= r_rgb;
              end else begin
                err <= 1'b1;
              end
            end
            c_OP_GET: begin
              rsp_valid <= 1'b1;
              if (w_in_range) begin
                rsp_ok    <= 1'b1;
                rsp_rgb24 <= r_mem[w_idx];
              end else begin
                rsp_ok    <= 1'b0;
                rsp_rgb24 <= 24'h000000;
                err       <= 1'b1;
              end
            end
            default: ;  // NOP opcodes only produce done
          endcase
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_image_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_image_top
//  Purpose  : Self-checking bench for pixel_image_top. A table of commands
//             with expected results is replayed; expected completions are
//             queued on issue and popped when done is observed. Hand-written
//             sequences cover busy-drop and reset during a sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_image_top;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  localparam logic [2:0] OP_FILL = 3'd0, OP_SET = 3'd1, OP_GET = 3'd2,
                         OP_INV  = 3'd3, OP_GRAY = 3'd4, OP_NOP = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [2:0]  cmd_x = 3'd0;
  logic [2:0]  cmd_y = 3'd0;
  logic [7:0]  cmd_r = 8'd0, cmd_g = 8'd0, cmd_b = 8'd0;
  logic        done, rsp_valid, rsp_ok, err;
  logic [7:0]  rsp_r, rsp_g, rsp_b;
  logic [23:0] rsp_rgb24;

  pixel_image_top #(.W(W), .H(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b),
    .done(done), .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
    .rsp_r(rsp_r), .rsp_g(rsp_g), .rsp_b(rsp_b),
    .rsp_rgb24(rsp_rgb24), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [23:0] rgb;
    logic        exp_ok;
    logic [23:0] exp_rgb;
    logic        exp_err;
  } vec_t;

  typedef struct {
    bit          is_get;
    bit          ok;
    logic [23:0] rgb;
    bit          err;
    int          lat;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[30];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input int x, input int y,
                              input logic [23:0] rgb, input logic ok,
                              input logic [23:0] ergb, input logic eerr);
    vec_t v;
    v.op = op; v.x = 3'(x); v.y = 3'(y); v.rgb = rgb;
    v.exp_ok = ok; v.exp_rgb = ergb; v.exp_err = eerr;
    return v;
  endfunction

  // Waits (bounded) for cmd_ready, drives one command and returns #1 after
  // the accepting edge with cmd_valid already dropped.
  task automatic accept(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                        input logic [23:0] rgb, output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = cmd_ready;
    if (!ok) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y;
      {cmd_r, cmd_g, cmd_b} = rgb;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  // Bounded wait for done; returns number of edges since acceptance.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    bit   ok;
    int   lat;
    e.is_get = (v.op == OP_GET);
    e.ok     = v.exp_ok;
    e.rgb    = v.exp_rgb;
    e.err    = v.exp_err;
    e.lat    = (v.op == OP_FILL || v.op == OP_INV || v.op == OP_GRAY) ? N : 1;
    sb.push_back(e);
    accept(v.op, v.x, v.y, v.rgb, ok);
    e = sb.pop_front();
    if (ok) begin
      @(posedge clk);
      #1 wait_done(lat);
      check("done_latency", 32'(lat), 32'(e.lat));
      check("rsp_valid", 32'(rsp_valid), 32'(e.is_get));
      check("err", 32'(err), 32'(e.err));
      if (e.is_get) begin
        check("rsp_ok", 32'(rsp_ok), 32'(e.ok));
        check("rsp_rgb24", 32'(rsp_rgb24), 32'(e.rgb));
        check("rsp_channels", 32'({rsp_r, rsp_g, rsp_b}), 32'(e.rgb));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_ok"}, 32'(rsp_ok), 32'd0);
    check({tag, "_rsp_rgb24"}, 32'(rsp_rgb24), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    bit ok;
    int lat;
    int dones;

    tbl[0]  = mk(OP_GET,  0, 0, 24'h0,      1, 24'h000000, 0);
    tbl[1]  = mk(OP_GET,  4, 0, 24'h0,      0, 24'h000000, 1);
    tbl[2]  = mk(OP_FILL, 0, 0, 24'h0000FF, 0, 24'h0,      0);
    tbl[3]  = mk(OP_SET,  0, 0, 24'hFF0000, 0, 24'h0,      0);
    tbl[4]  = mk(OP_SET,  1, 0, 24'h00FF00, 0, 24'h0,      0);
    tbl[5]  = mk(OP_SET,  2, 0, 24'hFFFFFF, 0, 24'h0,      0);
    tbl[6]  = mk(OP_SET,  3, 2, 24'h808000, 0, 24'h0,      0);
    tbl[7]  = mk(OP_GET,  2, 0, 24'h0,      1, 24'hFFFFFF, 0);
    tbl[8]  = mk(OP_GET,  1, 1, 24'h0,      1, 24'h0000FF, 0);
    tbl[9]  = mk(OP_INV,  0, 0, 24'h0,      0, 24'h0,      0);
    tbl[10] = mk(OP_GET,  0, 0, 24'h0,      1, 24'h00FFFF, 0);
    tbl[11] = mk(OP_GET,  1, 0, 24'h0,      1, 24'hFF00FF, 0);
    tbl[12] = mk(OP_GET,  2, 0, 24'h0,      1, 24'h000000, 0);
    tbl[13] = mk(OP_GET,  3, 2, 24'h0,      1, 24'h7F7FFF, 0);
    tbl[14] = mk(OP_GET,  1, 1, 24'h0,      1, 24'hFFFF00, 0);
    tbl[15] = mk(OP_GRAY, 0, 0, 24'h0,      0, 24'h0,      0);
    tbl[16] = mk(OP_GET,  0, 0, 24'h0,      1, 24'hB2B2B2, 0);
    tbl[17] = mk(OP_GET,  1, 0, 24'h0,      1, 24'h696969, 0);
    tbl[18] = mk(OP_GET,  2, 0, 24'h0,      1, 24'h000000, 0);
    tbl[19] = mk(OP_GET,  3, 2, 24'h0,      1, 24'h8D8D8D, 0);
    tbl[20] = mk(OP_GET,  1, 1, 24'h0,      1, 24'hE2E2E2, 0);
    tbl[21] = mk(OP_SET,  0, 2, 24'hFF00FF, 0, 24'h0,      0);
    tbl[22] = mk(OP_GET,  0, 2, 24'h0,      1, 24'hFF00FF, 0);
    tbl[23] = mk(OP_GET,  1, 2, 24'h0,      1, 24'hE2E2E2, 0);
    tbl[24] = mk(OP_SET,  0, 3, 24'h123456, 0, 24'h0,      1);
    tbl[25] = mk(OP_GET,  3, 3, 24'h0,      0, 24'h000000, 1);
    tbl[26] = mk(OP_GET,  7, 2, 24'h0,      0, 24'h000000, 1);
    tbl[27] = mk(OP_NOP,  0, 0, 24'hABCDEF, 0, 24'h0,      0);
    tbl[28] = mk(3'd7,    1, 1, 24'h0,      0, 24'h0,      0);
    tbl[29] = mk(OP_GET,  3, 2, 24'h0,      1, 24'h8D8D8D, 0);

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      run(tbl[i]);
    end

    // Command offered while busy must be dropped, not queued.
    accept(OP_FILL, 3'd0, 3'd0, 24'h123456, ok);
    if (ok) begin
      cmd_valid = 1'b1; cmd_op = OP_SET; cmd_x = 3'd0; cmd_y = 3'd0;
      {cmd_r, cmd_g, cmd_b} = 24'hAAAAAA;
      check("busy_ready_low", 32'(cmd_ready), 32'd0);
      repeat (5) @(posedge clk);
      #1 check("busy_ready_still_low", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      wait_done(lat);
      check("busy_fill_done", 32'(done), 32'd1);
    end
    run(mk(OP_GET, 0, 0, 24'h0, 1, 24'h123456, 0));
    run(mk(OP_GET, 3, 2, 24'h0, 1, 24'h123456, 0));

    // Reset in the middle of a sweep aborts it and clears the image.
    accept(OP_FILL, 3'd0, 3'd0, 24'hFFFFFF, ok);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    check("no_done_after_abort", 32'(dones), 32'd0);
    for (int p = 0; p < N; p++) begin
      run(mk(OP_GET, p % W, p / W, 24'h0, 1, 24'h000000, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
